one_vs_one_vote_ctrl: RTL and testbench
=======================================

ONE_VS_ONE_VOTE_CTRL -- requirements
Module: one_vs_one_vote_ctrl

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10, number of classes.
REQ-002 SHALL have parameter N_features, default 16, features per sample.
REQ-003 SHALL have parameters inputWidth, weightWidth and biasWidth, with defaults from the shared parameter set, giving the operand widths.
REQ-004 SHALL have derived localparam N_PAIRS = N_CLASSES*(N_CLASSES-1)/2 (45 at defaults).
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-007 in_valid / in_ready  in / out  1 / 1  sample handshake.
REQ-008 in_features  in  inputWidth*N_features  unsigned sample vector.
REQ-009 coef_addr_o  out  clog2(N_PAIRS)  current pair index into the coefficient ROM.
REQ-010 coef_weights_i / coef_bias_i  in  weightWidth*N_features / biasWidth  combinational ROM data.
REQ-011 svm_rst_n_o  out  1  synchronous active-low reset to the binary SVM datapath.
REQ-012 svm_weights_o / svm_bias_o / svm_inputs_o  out  same widths as coef_weights_i / coef_bias_i / in_features  operands to the binary SVM.
REQ-013 svm_class_i / svm_ready_i  in  1 / 1  decision bit (1 = negative) and result strobe from the binary SVM.
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-015 out_class  out  clog2(N_CLASSES)  predicted class.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> ARGMAX -> DONE -> IDLE.
REQ-017 IDLE: in_ready=1 and svm_rst_n_o=0; in_valid=1 SHALL latch in_features, clear all vote counters, set pair=0, and go to RUN.
REQ-018 in_ready SHALL be 0 in all states other than IDLE, and in_valid SHALL be ignored there.
REQ-019 RUN: svm_rst_n_o=1; svm_inputs_o is the latched sample; svm_weights_o and svm_bias_o pass coef_*_i through combinationally; coef_addr_o=pair.
REQ-020 Pair order SHALL be (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1); pair p maps to classes (i,j).
REQ-021 On a clock edge in RUN with svm_ready_i=1: svm_class_i=0 SHALL increment votes[i], otherwise votes[j]; pair SHALL then increment.
REQ-022 After the edge that samples the result for pair N_PAIRS-1, the FSM SHALL go to ARGMAX with svm_rst_n_o=0.
REQ-023 svm_ready_i SHALL be ignored outside RUN.
REQ-024 Expected SVM cadence: first strobe N_features+1 cycles after svm_rst_n_o rises, then one strobe every N_features+2 cycles; the pair advance is therefore settled before the next accumulation starts.
REQ-025 ARGMAX SHALL scan one class per cycle, c=0..N_CLASSES-1, keeping the best class; it SHALL replace the best only on strictly greater votes (ties resolve to the lowest index).
REQ-026 ARGMAX SHALL take exactly N_CLASSES cycles, then go to DONE.
REQ-027 DONE: out_valid=1 and out_class is held stable until out_ready=1, then the FSM SHALL go to IDLE.
REQ-028 Latency from the accept edge to out_valid high SHALL be N_PAIRS*(N_features+2)+N_CLASSES cycles (820 at defaults).
REQ-029 Vote counters SHALL be clog2(N_CLASSES) bits wide; the maximum count N_CLASSES-1 cannot overflow.

Reset
REQ-030 rst_n=0 at any clock edge, in any state including mid-RUN, SHALL force IDLE and clear pair, votes, best class, out_class and the feature register.
REQ-031 During reset SHALL drive out_valid=0, in_ready=1 (visible after the first reset edge), svm_rst_n_o=0 and coef_addr_o=0.

Structure
REQ-032 Package svm_pkg SHALL hold the FSM state enum, default widths, and the N_PAIRS and vote-width constants.
REQ-033 Sub-module ovo_pair_seq SHALL hold the pair counter and the (i,j) generator, with ports clear, advance, p, i, j and last.

Verification
REQ-034 Reset with rst_n=0 for 3 cycles -> out_valid=0, in_ready=1, svm_rst_n_o=0, coef_addr_o=0.
REQ-035 Behavioural SVM model always returning svm_class_i=0 -> votes[0]=9, out_class=0, out_valid at exactly 820 cycles after the accept edge.
REQ-036 Model always returning svm_class_i=1 -> votes[9]=9, out_class=9.
REQ-037 Model scripted so classes 2 and 5 both reach 7 votes (the maximum) -> out_class=2.
REQ-038 rst_n=0 at cycle 300 of RUN -> IDLE on the next cycle with votes cleared; a subsequent full run returns the correct class with 820-cycle latency.
REQ-039 out_ready held 0 for 50 cycles in DONE while in_valid=1 -> out_valid and out_class stay stable, in_ready=0, no new sample is accepted.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types and default sizing for the one-vs-one SVM vote controller.
package svm_pkg;

    localparam int INPUT_WIDTH_DEF  = 8;
    localparam int WEIGHT_WIDTH_DEF = 8;
    localparam int BIAS_WIDTH_DEF   = 16;
    localparam int N_CLASSES_DEF    = 10;
    localparam int N_FEATURES_DEF   = 16;
    localparam int N_PAIRS_DEF      = N_CLASSES_DEF * (N_CLASSES_DEF - 1) / 2;
    localparam int VOTE_W_DEF       = $clog2(N_CLASSES_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ARGMAX,
        ST_DONE
    } ovo_state_t;

endpackage

// File: rtl/ovo_pair_seq.sv
// Pair counter walking (0,1),(0,2)..(N-2,N-1) with the class indices tracked
// incrementally instead of decoded from the pair number.
module ovo_pair_seq
    import svm_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clear,
    input  logic                                      advance,
    output logic [$clog2(N_CLASSES*(N_CLASSES-1)/2)-1:0] p,
    output logic [$clog2(N_CLASSES)-1:0]              i,
    output logic [$clog2(N_CLASSES)-1:0]              j,
    output logic                                      last
);

    localparam int N_PAIRS = N_CLASSES * (N_CLASSES - 1) / 2;
    localparam int P_W     = $clog2(N_PAIRS);
    localparam int C_W     = $clog2(N_CLASSES);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            p <= '0;
            i <= '0;
            j <= C_W'(1);
        end else if (advance) begin
            p <= p + P_W'(1);
            // End of a row: next pair starts at (i+1, i+2)
            if (j == C_W'(N_CLASSES - 1)) begin
                i <= i + C_W'(1);
                j <= i + C_W'(2);
            end else begin
                j <= j + C_W'(1);
            end
        end
    end

    assign last = (p == P_W'(N_PAIRS - 1));

endmodule

// File: rtl/one_vs_one_vote_ctrl.sv
// Sequences a single binary SVM over every class pair, tallies the votes and
// reports the class with the most votes (lowest index wins a tie).
module one_vs_one_vote_ctrl
    import svm_pkg::*;
#(
    parameter int N_CLASSES   = N_CLASSES_DEF,
    parameter int N_features  = N_FEATURES_DEF,
    parameter int inputWidth  = INPUT_WIDTH_DEF,
    parameter int weightWidth = WEIGHT_WIDTH_DEF,
    parameter int biasWidth   = BIAS_WIDTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [inputWidth*N_features-1:0]            in_features,
    output logic [$clog2(N_CLASSES*(N_CLASSES-1)/2)-1:0] coef_addr_o,
    input  logic [weightWidth*N_features-1:0]           coef_weights_i,
    input  logic [biasWidth-1:0]                        coef_bias_i,
    output logic                                        svm_rst_n_o,
    output logic [weightWidth*N_features-1:0]           svm_weights_o,
    output logic [biasWidth-1:0]                        svm_bias_o,
    output logic [inputWidth*N_features-1:0]            svm_inputs_o,
    input  logic                                        svm_class_i,
    input  logic                                        svm_ready_i,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [$clog2(N_CLASSES)-1:0]                out_class,
    output ovo_state_t                                  dbg_state
);

    localparam int N_PAIRS = N_CLASSES * (N_CLASSES - 1) / 2;
    localparam int P_W     = $clog2(N_PAIRS);
    localparam int C_W     = $clog2(N_CLASSES);
    localparam int VOTE_W  = C_W;

    // Handshakes: a transfer happens on a posedge where valid and ready are
    // both high; valid never depends on ready, and ready only on state.
    ovo_state_t state, state_next;

    logic [inputWidth*N_features-1:0] features_q;
    logic [VOTE_W-1:0]                votes [N_CLASSES];
    logic [C_W-1:0]                   scan_c;
    logic [C_W-1:0]                   best_c;
    logic [VOTE_W-1:0]                best_v;
    logic [C_W-1:0]                   out_class_q;

    logic [P_W-1:0] pair_p;
    logic [C_W-1:0] pair_i, pair_j;
    logic           pair_last;

    logic           accept, strobe, scan_last, scan_better;
    logic [C_W-1:0] win_c;

    assign accept      = (state == ST_IDLE) && in_valid;
    assign strobe      = (state == ST_RUN) && svm_ready_i;
    assign scan_last   = (scan_c == C_W'(N_CLASSES - 1));
    assign scan_better = (votes[scan_c] > best_v);
    assign win_c       = svm_class_i ? pair_j : pair_i;

    ovo_pair_seq #(
        .N_CLASSES(N_CLASSES)
    ) u_pair_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .advance(strobe && !pair_last),
        .p      (pair_p),
        .i      (pair_i),
        .j      (pair_j),
        .last   (pair_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)                state_next = ST_RUN;
            ST_RUN:    if (strobe && pair_last)   state_next = ST_ARGMAX;
            ST_ARGMAX: if (scan_last)             state_next = ST_DONE;
            ST_DONE:   if (out_ready)             state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            features_q  <= '0;
            scan_c      <= '0;
            best_c      <= '0;
            best_v      <= '0;
            out_class_q <= '0;
            for (int k = 0; k < N_CLASSES; k++) votes[k] <= '0;
        end else begin
            if (accept) begin
                features_q <= in_features;
                scan_c     <= '0;
                best_c     <= '0;
                best_v     <= '0;
                for (int k = 0; k < N_CLASSES; k++) votes[k] <= '0;
            end
            if (strobe) begin
                votes[win_c] <= votes[win_c] + VOTE_W'(1);
            end
            // Strictly-greater replacement keeps the lowest index on ties
            if (state == ST_ARGMAX) begin
                scan_c <= scan_c + C_W'(1);
                if (scan_better) begin
                    best_c <= scan_c;
                    best_v <= votes[scan_c];
                end
                if (scan_last) begin
                    out_class_q <= scan_better ? scan_c : best_c;
                end
            end
        end
    end

    assign in_ready      = (state == ST_IDLE);
    assign svm_rst_n_o   = (state == ST_RUN);
    assign coef_addr_o   = pair_p;
    assign svm_weights_o = coef_weights_i;
    assign svm_bias_o    = coef_bias_i;
    assign svm_inputs_o  = features_q;
    assign out_valid     = (state == ST_DONE);
    assign out_class     = out_class_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_one_vs_one_vote_ctrl.sv
// Directed bench for one_vs_one_vote_ctrl with a cycle-accurate binary SVM model.
module tb_one_vs_one_vote_ctrl;
    import svm_pkg::*;

    localparam int NC   = 10;
    localparam int NF   = 16;
    localparam int IW   = 8;
    localparam int WW   = 8;
    localparam int BW   = 16;
    localparam int LAT  = 45 * (NF + 2) + NC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IW*NF-1:0]  in_features;
    logic [5:0]        coef_addr_o;
    logic [WW*NF-1:0]  coef_weights_i;
    logic [BW-1:0]     coef_bias_i;
    logic              svm_rst_n_o;
    logic [WW*NF-1:0]  svm_weights_o;
    logic [BW-1:0]     svm_bias_o;
    logic [IW*NF-1:0]  svm_inputs_o;
    logic              svm_class_i;
    logic              svm_ready_i;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_class;
    ovo_state_t        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int svm_cnt  = 0;
    int lat;

    always #5 clk = ~clk;

    one_vs_one_vote_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_features   (in_features),
        .coef_addr_o   (coef_addr_o),
        .coef_weights_i(coef_weights_i),
        .coef_bias_i   (coef_bias_i),
        .svm_rst_n_o   (svm_rst_n_o),
        .svm_weights_o (svm_weights_o),
        .svm_bias_o    (svm_bias_o),
        .svm_inputs_o  (svm_inputs_o),
        .svm_class_i   (svm_class_i),
        .svm_ready_i   (svm_ready_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_class     (out_class),
        .dbg_state     (dbg_state)
    );

    // Pair number -> (i, j), returned as i*16 + j
    function automatic int pair_ij(int p);
        int n = 0;
        for (int a = 0; a < NC; a++)
            for (int b = a + 1; b < NC; b++) begin
                if (n == p) return a * 16 + b;
                n++;
            end
        return 0;
    endfunction

    // Script giving votes {5,5,7,4,3,7,4,3,4,3}: classes 2 and 5 tie at 7
    function automatic logic script_bit(int i, int j);
        if (i == 2) return 1'b0;
        if (j == 2) return 1'b0;
        if (i == 1 && j == 5) return 1'b0;
        if (j == 5) return 1'b1;
        if (i == 5) return 1'b0;
        return ((i + j) % 2 == 1) ? 1'b0 : 1'b1;
    endfunction

    always_comb begin
        int ij;
        ij = pair_ij(int'(coef_addr_o));
        svm_class_i = 1'b0;
        if (mode == 1) svm_class_i = 1'b1;
        else if (mode == 2) svm_class_i = script_bit(ij / 16, ij % 16);
    end

    // Binary SVM cadence: first result NF+1 cycles after release, then every NF+2
    always @(posedge clk) begin
        if (!svm_rst_n_o) svm_cnt <= 0;
        else svm_cnt <= (svm_cnt == NF + 1) ? 0 : svm_cnt + 1;
    end
    assign svm_ready_i    = svm_rst_n_o && (svm_cnt == NF + 1);
    assign coef_weights_i = {NF{2'b00, coef_addr_o}};
    assign coef_bias_i    = {10'd0, coef_addr_o};

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic accept_sample(input logic [IW*NF-1:0] feat);
        @(negedge clk);
        in_features = feat;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("run_in_ready", in_ready, 1'b0);
        check_eq("run_svm_rst", svm_rst_n_o, 1'b1);
        check_eq("run_inputs", svm_inputs_o, feat);
        check_eq("run_addr0", coef_addr_o, 6'd0);
    endtask

    task automatic run_sample(input logic [IW*NF-1:0] feat, output int latency);
        accept_sample(feat);
        latency = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (k == NF + 1) check_eq("weights_pass", svm_weights_o, coef_weights_i);
            if (k == NF + 2) check_eq("addr_after_first", coef_addr_o, 6'd1);
            if (out_valid) begin
                latency = k;
                break;
            end
        end
        check_eq("latency", latency, LAT);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("rel_in_ready", in_ready, 1'b1);
        check_eq("rel_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_features = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_svm_rst", svm_rst_n_o, 1'b0);
        check_eq("rst_addr", coef_addr_o, 6'd0);
        check_eq("rst_out_class", out_class, 4'd0);
        rst_n = 1'b1;

        // All pairs resolve to the lower class
        mode = 0;
        run_sample({4{32'hA5A5_0101}}, lat);
        check_eq("m0_class", out_class, 4'd0);
        check_eq("m0_votes0", dut.votes[0], 4'd9);
        check_eq("m0_votes9", dut.votes[9], 4'd0);

        // Result held while the consumer stalls and a new sample waits
        @(negedge clk);
        in_valid    = 1'b1;
        in_features = {4{32'hDEAD_BEEF}};
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_class", out_class, 4'd0);
            check_eq("hold_in_ready", in_ready, 1'b0);
        end
        release_result();
        check_eq("hold_no_accept", svm_inputs_o, {4{32'hA5A5_0101}});

        // All pairs resolve to the higher class
        mode = 1;
        run_sample({4{32'h1234_5678}}, lat);
        check_eq("m1_class", out_class, 4'd9);
        check_eq("m1_votes9", dut.votes[9], 4'd9);
        check_eq("m1_votes0", dut.votes[0], 4'd0);
        release_result();

        // Tie between classes 2 and 5 resolves to the lower index
        mode = 2;
        run_sample({4{32'h0F0F_F0F0}}, lat);
        check_eq("tie_class", out_class, 4'd2);
        check_eq("tie_votes2", dut.votes[2], 4'd7);
        check_eq("tie_votes5", dut.votes[5], 4'd7);
        check_eq("tie_votes0", dut.votes[0], 4'd5);
        check_eq("tie_votes4", dut.votes[4], 4'd3);
        release_result();

        // Reset in the middle of RUN, then a clean run
        mode = 1;
        accept_sample({4{32'h5555_AAAA}});
        repeat (300) @(posedge clk);
        #1;
        check_eq("mid_votes2", dut.votes[2], 4'd2);
        check_eq("mid_addr", coef_addr_o, 6'd16);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_state", dbg_state, ST_IDLE);
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        check_eq("mid_rst_svm_rst", svm_rst_n_o, 1'b0);
        check_eq("mid_rst_addr", coef_addr_o, 6'd0);
        check_eq("mid_rst_votes2", dut.votes[2], 4'd0);
        check_eq("mid_rst_inputs", svm_inputs_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sample({4{32'h0BAD_CAFE}}, lat);
        check_eq("post_rst_class", out_class, 4'd9);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
